// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one single-port memory bus between two requesters
// Bursts are capped at MAX_BURST beats; read data is steered back by a one-entry owner tag.
module mem_port_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_wr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_wr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  state_t            state;
  logic [CW-1:0]     beat_cnt;
  logic              last_grant;
  logic              mem_tag;
  logic              rd_pend;
  logic              rd_tag;
  logic [DATA_W-1:0] hold0;
  logic [DATA_W-1:0] hold1;

  logic              owner;
  logic              own_valid;
  logic              own_wr;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              accept;
  logic              burst_done;
  logic              rearb;
  logic              arb_any;
  logic              arb_win;

  assign req0_ready = (state == G0);
  assign req1_ready = (state == G1);

  assign owner      = (state == G1);
  assign own_valid  = owner ? req1_valid : req0_valid;
  assign own_wr     = owner ? req1_wr    : req0_wr;
  assign own_addr   = owner ? req1_addr  : req0_addr;
  assign own_wdata  = owner ? req1_wdata : req0_wdata;

  assign accept     = (state != IDLE) && own_valid;
  assign burst_done = accept && (beat_cnt == CW'(MAX_BURST - 1));
  assign rearb      = (state == IDLE) || !own_valid || burst_done;

  // While granted, last_grant equals the owner, so idle arbitration and
  // release arbitration share one rule: prefer the requester that did not win last.
  assign arb_any    = req0_valid | req1_valid;
  assign arb_win    = last_grant ? !req0_valid : req1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      last_grant <= 1'b1;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_tag    <= 1'b0;
      rd_pend    <= 1'b0;
      rd_tag     <= 1'b0;
      hold0      <= '0;
      hold1      <= '0;
    end else begin
      if (rearb) begin
        beat_cnt <= '0;
        if (arb_any) begin
          state      <= arb_win ? G1 : G0;
          last_grant <= arb_win;
        end else begin
          state <= IDLE;
        end
      end else begin
        beat_cnt <= beat_cnt + CW'(1);
      end

      mem_en <= accept;
      mem_wr <= accept && own_wr;
      if (accept) begin
        mem_addr  <= own_addr;
        mem_wdata <= own_wdata;
        mem_tag   <= owner;
      end

      // Tag follows the access one cycle so it lines up with mem_rdata.
      rd_pend <= mem_en && !mem_wr;
      rd_tag  <= mem_tag;
      if (req0_rvalid) hold0 <= mem_rdata;
      if (req1_rvalid) hold1 <= mem_rdata;
    end
  end

  assign req0_rvalid = rd_pend && !rd_tag;
  assign req1_rvalid = rd_pend &&  rd_tag;
  assign req0_rdata  = req0_rvalid ? mem_rdata : hold0;
  assign req1_rdata  = req1_rvalid ? mem_rdata : hold1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a transaction model
module tb_mem_port_arbiter;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       vld [2];
  logic       wr  [2];
  logic [5:0] ad  [2];
  logic [7:0] wd  [2];

  logic       req0_ready, req1_ready, req0_rvalid, req1_rvalid;
  logic [7:0] req0_rdata, req1_rdata;
  logic       mem_en, mem_wr;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  mem_port_arbiter #(.ADDR_W(6), .DATA_W(8), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(vld[0]), .req0_ready(req0_ready), .req0_addr(ad[0]), .req0_wr(wr[0]),
    .req0_wdata(wd[0]), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(vld[1]), .req1_ready(req1_ready), .req1_addr(ad[1]), .req1_wr(wr[1]),
    .req1_wdata(wd[1]), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] init_val(input int i);
    if (i == 5) return 8'hA5;
    return 8'(i * 37 + 11);
  endfunction

  // Memory macro stand-in: synchronous read, one-cycle latency.
  logic       load;
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      mem_rdata <= 8'h00;
    end else if (mem_en) begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Reference model: grant ownership and expected bus/response values.
  int         own, last, cnt, e_tag;
  logic       e_en, e_wr;
  logic [5:0] e_addr;
  logic [7:0] e_wdata;
  logic       e_rv [2];
  logic [7:0] e_rd [2];
  logic [7:0] ref_mem [64];
  bit         acc [2];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    own = -1; last = 1; cnt = 0; e_tag = 0;
    e_en = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
    for (int n = 0; n < 2; n++) begin e_rv[n] = 0; e_rd[n] = '0; acc[n] = 0; end
  endtask

  // Predict what the DUT shows after the next rising edge, given current inputs.
  task automatic step();
    bit rel;
    int n;
    acc[0] = 0; acc[1] = 0;
    if (!rst_n) begin reset_model(); return; end
    e_rv[0] = 0; e_rv[1] = 0;
    if (e_en && !e_wr) begin e_rv[e_tag] = 1; e_rd[e_tag] = ref_mem[e_addr]; end
    if (e_en && e_wr) ref_mem[e_addr] = e_wdata;
    e_en = 0; e_wr = 0;
    if (own >= 0 && vld[own]) begin
      acc[own] = 1; e_en = 1; e_wr = wr[own]; e_addr = ad[own]; e_wdata = wd[own]; e_tag = own;
    end
    if (own < 0) begin
      if (vld[0] || vld[1]) begin
        own = vld[1-last] ? 1 - last : last;
        last = own; cnt = 0;
      end
    end else begin
      n = own;
      if (vld[n]) begin cnt++; rel = (cnt == MAXB); end
      else rel = 1;
      if (rel) begin
        cnt = 0;
        if (vld[1-n])   own = 1 - n;
        else if (vld[n]) own = n;
        else            own = -1;
        if (own >= 0) last = own;
      end
    end
  endtask

  task automatic cyc();
    step();
    @(negedge clk);
    chk("ready0",    req0_ready,  own == 0);
    chk("ready1",    req1_ready,  own == 1);
    chk("mem_en",    mem_en,      e_en);
    chk("mem_wr",    mem_wr,      e_wr);
    chk("mem_addr",  mem_addr,    e_addr);
    chk("mem_wdata", mem_wdata,   e_wdata);
    chk("rvalid0",   req0_rvalid, e_rv[0]);
    chk("rvalid1",   req1_rvalid, e_rv[1]);
    chk("rdata0",    req0_rdata,  e_rd[0]);
    chk("rdata1",    req1_rdata,  e_rd[1]);
  endtask

  task automatic wait_acc(input int n, output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      lat++;
      if (acc[n]) return;
    end
    errors++;
    $error("FAIL wait_acc%0d: observed no acceptance expected acceptance within 20 cycles", n);
  endtask

  int lat;
  int pct [2];

  initial begin
    rst_n = 1'b0; load = 1'b1;
    for (int n = 0; n < 2; n++) begin vld[n] = 0; wr[n] = 0; ad[n] = '0; wd[n] = '0; end
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    reset_model();
    cyc(); cyc();
    rst_n = 1'b1; load = 1'b0;
    cyc();

    // Single read: ready at c1, access at c2, data at c3.
    vld[0] = 1; ad[0] = 6'd5; wr[0] = 0;
    wait_acc(0, lat);
    chk("t1_latency", lat, 2);
    chk("t1_mem_en", mem_en, 1'b1);
    chk("t1_mem_addr", mem_addr, 6'd5);
    vld[0] = 0;
    cyc();
    chk("t1_rvalid0", req0_rvalid, 1'b1);
    chk("t1_rdata0", req0_rdata, 8'hA5);
    chk("t1_rvalid1", req1_rvalid, 1'b0);
    cyc();

    // Write then read back the top address.
    vld[0] = 1; ad[0] = 6'd63; wr[0] = 1; wd[0] = 8'h3C;
    wait_acc(0, lat);
    chk("t5_mem_wr", mem_wr, 1'b1);
    chk("t5_mem_addr", mem_addr, 6'd63);
    chk("t5_mem_wdata", mem_wdata, 8'h3C);
    wr[0] = 0;
    cyc();
    chk("t5_rd_en", mem_en, 1'b1);
    chk("t5_rd_wr", mem_wr, 1'b0);
    vld[0] = 0;
    cyc();
    chk("t5_rvalid0", req0_rvalid, 1'b1);
    chk("t5_rdata0", req0_rdata, 8'h3C);
    cyc();

    // Reset while a read is on the bus.
    vld[0] = 1; ad[0] = 6'd10; wr[0] = 0;
    wait_acc(0, lat);
    chk("t6_pre_en", mem_en, 1'b1);
    vld[0] = 0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_en", mem_en, 1'b0);
    chk("t6_rst_addr", mem_addr, 6'd0);
    chk("t6_rst_ready0", req0_ready, 1'b0);
    chk("t6_rst_rvalid0", req0_rvalid, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t6_no_rvalid0", req0_rvalid, 1'b0);
    cyc();
    vld[0] = 1; vld[1] = 1; ad[0] = 6'd1; ad[1] = 6'd2;
    cyc();
    chk("t6_first_grant0", req0_ready, 1'b1);
    chk("t6_first_grant1", req1_ready, 1'b0);

    // Randomized segments: contention, sole requester 1, mixed.
    for (int seg = 0; seg < 4; seg++) begin
      case (seg)
        0:       begin pct[0] = 100; pct[1] = 100; end
        1:       begin pct[0] = 0;   pct[1] = 100; end
        2:       begin pct[0] = 50;  pct[1] = 50;  end
        default: begin pct[0] = 30;  pct[1] = 80;  end
      endcase
      for (int c = 0; c < 700; c++) begin
        for (int n = 0; n < 2; n++) begin
          if (!(vld[n] && !acc[n])) begin
            vld[n] = ($urandom_range(99) < pct[n]);
            ad[n]  = 6'($urandom);
            wr[n]  = 1'($urandom);
            wd[n]  = 8'($urandom);
          end
        end
        cyc();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
